// File: rtl/cond_pkg.sv
// Shared types and constants for the condition unit.
// Condition encodings follow the instruction Cond field, bits [31:28].
package cond_pkg;

    typedef enum logic [3:0] {
        CondEq = 4'b0000,
        CondNe = 4'b0001,
        CondCs = 4'b0010,
        CondCc = 4'b0011,
        CondMi = 4'b0100,
        CondPl = 4'b0101,
        CondVs = 4'b0110,
        CondVc = 4'b0111,
        CondHi = 4'b1000,
        CondLs = 4'b1001,
        CondGe = 4'b1010,
        CondLt = 4'b1011,
        CondGt = 4'b1100,
        CondLe = 4'b1101,
        CondAl = 4'b1110,
        CondNv = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Bit positions inside FlagW
    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// Cond field passes against the stored {N,Z,C,V} flags.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);
    import cond_pkg::*;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];

    // Decode the condition field into a single pass bit
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond_e'(cond))
            CondEq:  cond_pass = flag_z;
            CondNe:  cond_pass = ~flag_z;
            CondCs:  cond_pass = flag_c;
            CondCc:  cond_pass = ~flag_c;
            CondMi:  cond_pass = flag_n;
            CondPl:  cond_pass = ~flag_n;
            CondVs:  cond_pass = flag_v;
            CondVc:  cond_pass = ~flag_v;
            CondHi:  cond_pass = flag_c & ~flag_z;
            CondLs:  cond_pass = ~flag_c | flag_z;
            CondGe:  cond_pass = (flag_n == flag_v);
            CondLt:  cond_pass = (flag_n != flag_v);
            CondGt:  cond_pass = ~flag_z & (flag_n == flag_v);
            CondLe:  cond_pass = flag_z | (flag_n != flag_v);
            CondAl:  cond_pass = 1'b1;
            CondNv:  cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition unit and NZCV flag register for the single-cycle processor.
// Gates raw PC/register/memory write strobes by the evaluated condition and
// updates the two flag halves independently under FlagW.
// Optional macro COND_PERF_CNT_EN adds executed/squashed instruction counters
// with a synchronous clear.
module cond_logic #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
`ifdef COND_PERF_CNT_EN
    input  logic             CntClr,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt,
`endif
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags
);
    import cond_pkg::*;

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_pass;

    // Condition is judged only against the registered flags, so a flag
    // setter never influences its own execution.
    cond_check u_cond_check (
        .cond      (Cond),
        .flags     (flags_q),
        .cond_pass (cond_pass)
    );

    // Gate the raw write strobes with the executed-condition bit
    always_comb begin
        CondEx   = cond_pass & InstrValid;
        PCSrc    = PCS & CondEx;
        RegWrite = RegW & CondEx & ~NoWrite;
        MemWrite = MemW & CondEx;
    end

    // Next flag value: each half loads only when requested and executed
    always_comb begin
        flags_d = flags_q;
        if (FlagW[FLAGW_NZ] && CondEx) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (FlagW[FLAGW_CV] && CondEx) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] exec_d;
    logic [CNT_W-1:0] squash_q;
    logic [CNT_W-1:0] squash_d;

    // Counter next state; clear wins over a coincident increment
    always_comb begin
        exec_d   = exec_q;
        squash_d = squash_q;
        if (CntClr) begin
            exec_d   = '0;
            squash_d = '0;
        end else if (InstrValid) begin
            if (CondEx) begin
                exec_d = exec_q + CNT_W'(1);
            end else begin
                squash_d = squash_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign ExecCnt   = exec_q;
    assign SquashCnt = squash_q;
`else
    // Counter width is meaningless without the counters; keep it referenced
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed steps from the test plan plus
// randomized instructions checked against a behavioural flag/condition model.
module tb_cond_logic;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             InstrValid;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
`ifdef COND_PERF_CNT_EN
    logic             CntClr;
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SquashCnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference state
    bit [3:0]         m_flags;
    bit [CNT_W-1:0]   m_exec;
    bit [CNT_W-1:0]   m_squash;

    always #5 clk = ~clk;

    cond_logic #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstrValid (InstrValid),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
`ifdef COND_PERF_CNT_EN
        .CntClr     (CntClr),
        .ExecCnt    (ExecCnt),
        .SquashCnt  (SquashCnt),
`endif
        .CondEx     (CondEx),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Flags      (Flags)
    );

    // Conditions come in true/inverted pairs: even code tests a predicate,
    // the following odd code tests its negation (AL/NV being "always").
    function automatic bit cond_ref(input bit [3:0] c, input bit [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        bit [7:0] pred;
        bit base;
        pred[0] = z;
        pred[1] = cy;
        pred[2] = n;
        pred[3] = v;
        pred[4] = cy && !z;
        pred[5] = (n == v);
        pred[6] = !z && (n == v);
        pred[7] = 1'b1;
        base = pred[c[3:1]];
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction: drive on the falling edge, check combinational outputs
    // and current state, advance the model, then let the rising edge commit.
    task automatic step(input bit valid, input bit [3:0] c, input bit [3:0] alu,
                        input bit [1:0] fw, input bit pcs, input bit regw,
                        input bit memw, input bit nowr, input bit clr);
        bit ex;
        @(negedge clk);
        InstrValid = valid;
        Cond       = c;
        ALUFlags   = alu;
        FlagW      = fw;
        PCS        = pcs;
        RegW       = regw;
        MemW       = memw;
        NoWrite    = nowr;
`ifdef COND_PERF_CNT_EN
        CntClr     = clr;
`endif
        #1;
        ex = valid && cond_ref(c, m_flags);
        chk("condex",   {63'd0, CondEx},   {63'd0, ex});
        chk("pcsrc",    {63'd0, PCSrc},    {63'd0, ex && pcs});
        chk("regwrite", {63'd0, RegWrite}, {63'd0, ex && regw && !nowr});
        chk("memwrite", {63'd0, MemWrite}, {63'd0, ex && memw});
        chk("flags",    {60'd0, Flags},    {60'd0, m_flags});
`ifdef COND_PERF_CNT_EN
        chk("execcnt",   64'(ExecCnt),   64'(m_exec));
        chk("squashcnt", 64'(SquashCnt), 64'(m_squash));
`endif
        if (ex && fw[1]) m_flags[3:2] = alu[3:2];
        if (ex && fw[0]) m_flags[1:0] = alu[1:0];
        if (clr) begin
            m_exec   = '0;
            m_squash = '0;
        end else if (valid) begin
            if (ex) m_exec = m_exec + 1'b1;
            else    m_squash = m_squash + 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        InstrValid = 1'b1;
        Cond       = 4'b1110;
        ALUFlags   = 4'b0000;
        FlagW      = 2'b00;
        PCS        = 1'b0;
        RegW       = 1'b1;
        MemW       = 1'b0;
        NoWrite    = 1'b0;
`ifdef COND_PERF_CNT_EN
        CntClr     = 1'b0;
`endif
        m_flags  = '0;
        m_exec   = '0;
        m_squash = '0;

        // Behaviour while held in reset
        #12;
        chk("rst_flags", {60'd0, Flags}, 64'd0);
        chk("rst_al_regwrite", {63'd0, RegWrite}, 64'd1);
        Cond = 4'b0000;
        #1;
        chk("rst_eq_condex", {63'd0, CondEx}, 64'd0);
        chk("rst_eq_regwrite", {63'd0, RegWrite}, 64'd0);
        InstrValid = 1'b0;
        Cond = 4'b1110;
        #1;
        chk("rst_bubble_regwrite", {63'd0, RegWrite}, 64'd0);
`ifdef COND_PERF_CNT_EN
        chk("rst_execcnt", 64'(ExecCnt), 64'd0);
        chk("rst_squashcnt", 64'(SquashCnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Reset-state AL and EQ
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        // Write Z then test EQ/NE; ADDSEQ-style self-condition uses old Z
        step(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
        step(1, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
        // Partial update from 0011
        step(1, 4'b1110, 4'b0011, 2'b11, 0, 0, 0, 0, 0);
        step(1, 4'b1110, 4'b1000, 2'b10, 0, 0, 0, 0, 0);
        #1;
        chk("partial_upd", {60'd0, Flags}, 64'hb);
        // Squash protection: Z=0, EQ with FlagW=11
        step(1, 4'b0000, 4'b0100, 2'b11, 0, 0, 1, 0, 0);
        #1;
        chk("squash_hold", {60'd0, Flags}, 64'hb);
        // Compare under AL sets flags but no register write
        step(1, 4'b1110, 4'b1001, 2'b11, 0, 1, 0, 1, 0);
        #1;
        chk("cmp_flags", {60'd0, Flags}, 64'h9);
        // Signed conditions with N=1,V=1
        step(1, 4'b1010, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        step(1, 4'b1011, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        step(1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        step(1, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        // Bubble with write requests must not touch flags
        step(0, 4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 0);
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        // Back-to-back flag setters, each gated by the previous result
        step(1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, 2'b11, 0, 1, 0, 0, 0);
        step(1, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
        step(1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0);

`ifdef COND_PERF_CNT_EN
        // Counter tallies: 5 executed, 3 squashed, 2 bubbles
        step(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        #1;
        chk("cnt_exec5", 64'(ExecCnt), 64'd5);
        chk("cnt_squash3", 64'(SquashCnt), 64'd3);
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        #1;
        chk("cnt_clr_exec", 64'(ExecCnt), 64'd0);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset between clock edges
        step(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
        @(negedge clk);
        InstrValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {60'd0, Flags}, 64'd0);
`ifdef COND_PERF_CNT_EN
        chk("async_rst_exec", 64'(ExecCnt), 64'd0);
        chk("async_rst_squash", 64'(SquashCnt), 64'd0);
`endif
        m_flags  = '0;
        m_exec   = '0;
        m_squash = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
